// File: rtl/rx_buffer_pkg.sv
// Shared types for the UART receive-side word buffer.
package rx_buffer_pkg;
    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {B0, B1, B2, B3} byte_idx_e;
endpackage

// File: rtl/receiver_buffer_word_fifo.sv
// Word FIFO with first-word-fall-through read and registered full/empty flags.
module word_fifo
    import rx_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  word_t data_i,
    input  logic  pop_i,
    output word_t data_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    word_t                 mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, tail_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, valid_q;
    logic                  push_ok, pop_ok;

    // A pop on an empty FIFO is ignored, so a push into an empty FIFO never bypasses.
    assign pop_ok  = pop_i & valid_q;
    assign push_ok = push_i & (~full_q | pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (push_ok) tail_q <= tail_q + PTR_ONE;
            if (pop_ok)  head_q <= head_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            valid_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= data_i;
    end

    assign data_o  = valid_q ? mem_q[head_q] : '0;
    assign full_o  = full_q;
    assign empty_o = ~valid_q;
endmodule

// File: rtl/receiver_buffer.sv
// Packs UART bytes big-endian into 32-bit words and queues them for the CPU.
module receiver_buffer
    import rx_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2    = 5,
    parameter int RESYNC_CYCLES = 0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       read_req,
    output word_t      out_data,
    output logic       out_valid,
    output logic       full,
    output logic       overflow,
    input  logic       clear_overflow
);
    localparam int SHIFT_W = (WORD_BYTES - 1) * 8;
    localparam int IDLE_W  = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RESYNC_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    byte_idx_e            idx_q, idx_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic                 overflow_q, overflow_d;
    logic                 push, drop, fifo_full, fifo_empty;
    word_t                word;

    assign word = {shift_q, in_data};

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        idle_d  = '0;
        push    = 1'b0;
        if (in_valid) begin
            shift_d = {shift_q[SHIFT_W-9:0], in_data};
            unique case (idx_q)
                B0: idx_d = B1;
                B1: idx_d = B2;
                B2: idx_d = B3;
                B3: begin
                    idx_d = B0;
                    push  = 1'b1;
                end
            endcase
        end else if (RESYNC_CYCLES != 0 && idx_q != B0) begin
            // Discard on the edge that completes the RESYNC_CYCLES-th idle cycle.
            if (idle_q + IDLE_ONE == IDLE_LAST) begin
                idx_d   = B0;
                shift_d = '0;
            end else begin
                idle_d = idle_q + IDLE_ONE;
            end
        end
    end

    assign drop       = push & fifo_full & ~(read_req & ~fifo_empty);
    assign overflow_d = (overflow_q & ~clear_overflow) | drop;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            idx_q      <= B0;
            shift_q    <= '0;
            idle_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            idle_q     <= idle_d;
            overflow_q <= overflow_d;
        end
    end

    word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk     (CLK),
        .rst_n   (reset),
        .push_i  (push),
        .data_i  (word),
        .pop_i   (read_req),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign full      = fifo_full;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_receiver_buffer.sv
// Self-checking bench for receiver_buffer: vector table, directed corner cases, random vs. queue model.
module tb_receiver_buffer;
    import rx_buffer_pkg::*;

    localparam int DEPTH  = 32;
    localparam int RESYNC = 8;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       read_req = 1'b0;
    logic       clear_overflow = 1'b0;
    word_t      out_data;
    logic       out_valid, full, overflow;

    int n_cmp = 0;
    int n_err = 0;

    receiver_buffer #(.DEPTH_LOG2(5), .RESYNC_CYCLES(RESYNC)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .read_req       (read_req),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 CLK = ~CLK;

    // Reference model: queued words, pending bytes of the current word, idle run length.
    word_t      mq[$];
    logic [7:0] pb[$];
    int         m_idle = 0;
    bit         m_ovf = 1'b0;

    function automatic void model_reset();
        mq.delete();
        pb.delete();
        m_idle = 0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_step(bit iv, logic [7:0] d, bit rd, bit clr);
        bit    pop_ok;
        bit    drop;
        word_t w;
        drop   = 1'b0;
        pop_ok = rd && (mq.size() > 0);
        if (pop_ok) void'(mq.pop_front());
        if (iv) begin
            m_idle = 0;
            pb.push_back(d);
            if (pb.size() == 4) begin
                w = {pb[0], pb[1], pb[2], pb[3]};
                pb.delete();
                if (mq.size() < DEPTH) mq.push_back(w);
                else drop = 1'b1;
            end
        end else if (pb.size() > 0) begin
            m_idle++;
            if (m_idle == RESYNC) begin
                pb.delete();
                m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
        if (clr)  m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
    endfunction

    task automatic check_model(input string nm);
        bit    ev, ef;
        word_t ed;
        ev = (mq.size() != 0);
        ed = ev ? mq[0] : 32'h0;
        ef = (mq.size() == DEPTH);
        n_cmp++;
        if (out_valid !== ev || out_data !== ed || full !== ef || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL %s @%0t: got v=%0b d=%h f=%0b o=%0b, expected v=%0b d=%h f=%0b o=%0b",
                     nm, $time, out_valid, out_data, full, overflow, ev, ed, ef, m_ovf);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [7:0] d, input bit rd, input bit clr, input string nm);
        in_valid       = iv;
        in_data        = d;
        read_req       = rd;
        clear_overflow = clr;
        @(posedge CLK);
        #1;
        model_step(iv, d, rd, clr);
        check_model(nm);
    endtask

    task automatic send_word(input word_t w, input bit rd_first, input bit rd_last, input string nm);
        drive(1'b1, w[31:24], rd_first, 1'b0, nm);
        drive(1'b1, w[23:16], 1'b0, 1'b0, nm);
        drive(1'b1, w[15:8],  1'b0, 1'b0, nm);
        drive(1'b1, w[7:0],   rd_last, 1'b0, nm);
    endtask

    task automatic do_reset();
        in_valid       = 1'b0;
        in_data        = '0;
        read_req       = 1'b0;
        clear_overflow = 1'b0;
        reset          = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();
        check_model("reset");
        reset = 1'b1;
    endtask

    typedef struct {
        bit         iv;
        logic [7:0] d;
        bit         rd;
        bit         clr;
        bit         ev;
        word_t      ed;
        bit         ef;
        bit         eo;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int nidle;
        word_t prev;

        tbl[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 32'hABCDEF01, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'hABCDEF01, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};

        do_reset();
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);

        // Vector table: first word, pops, empty pop, push+pop on empty.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].rd, tbl[i].clr, "tbl_model");
            n_cmp++;
            if (out_valid !== tbl[i].ev || out_data !== tbl[i].ed ||
                full !== tbl[i].ef || overflow !== tbl[i].eo) begin
                n_err++;
                $display("FAIL tbl[%0d]: got v=%0b d=%h f=%0b o=%0b, expected v=%0b d=%h f=%0b o=%0b",
                         i, out_valid, out_data, full, overflow,
                         tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].eo);
            end
        end

        // Fill to 32, overflow on the 33rd, set beats clear, drain in order.
        do_reset();
        for (int i = 0; i < 33; i++) begin
            send_word(32'h2000_0000 + i, 1'b0, 1'b0, "fill");
            if (i == 30) chk("full_at_31", {31'b0, full}, 32'h0);
            if (i == 31) begin
                chk("full_at_32", {31'b0, full}, 32'h1);
                chk("no_ovf_at_32", {31'b0, overflow}, 32'h0);
            end
        end
        chk("ovf_at_33", {31'b0, overflow}, 32'h1);
        drive(1'b1, 8'h11, 1'b0, 1'b0, "ovf2");
        drive(1'b1, 8'h22, 1'b0, 1'b0, "ovf2");
        drive(1'b1, 8'h33, 1'b0, 1'b0, "ovf2");
        drive(1'b1, 8'h44, 1'b0, 1'b1, "ovf2");
        chk("ovf_set_wins", {31'b0, overflow}, 32'h1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        chk("ovf_cleared", {31'b0, overflow}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            chk("drain_order", out_data, 32'h2000_0000 + i);
            drive(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        chk("drain_empty", {31'b0, out_valid}, 32'h0);

        // Full FIFO: final byte coincides with a pop.
        do_reset();
        for (int i = 0; i < 32; i++) send_word(32'h3000_0000 + i, 1'b0, 1'b0, "fill3");
        drive(1'b1, 8'hDE, 1'b0, 1'b0, "pp_full");
        drive(1'b1, 8'hAD, 1'b0, 1'b0, "pp_full");
        drive(1'b1, 8'hBE, 1'b0, 1'b0, "pp_full");
        drive(1'b1, 8'hEF, 1'b1, 1'b0, "pp_full");
        chk("pp_full_still_full", {31'b0, full}, 32'h1);
        chk("pp_full_no_ovf", {31'b0, overflow}, 32'h0);
        chk("pp_full_head", out_data, 32'h3000_0001);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("pp_full_last", out_data, 32'hDEADBEEF);
            drive(1'b0, 8'h00, 1'b1, 1'b0, "drain3");
        end
        chk("drain3_empty", {31'b0, out_valid}, 32'h0);

        // Resync: 8 idle cycles drop a partial word, 7 do not.
        do_reset();
        drive(1'b1, 8'hAA, 1'b0, 1'b0, "rs");
        drive(1'b1, 8'hBB, 1'b0, 1'b0, "rs");
        for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, "rs_idle");
        send_word(32'h01020304, 1'b0, 1'b0, "rs");
        chk("resync_word", out_data, 32'h01020304);
        drive(1'b0, 8'h00, 1'b1, 1'b0, "rs_pop");
        chk("resync_single", {31'b0, out_valid}, 32'h0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0, "rs7");
        drive(1'b1, 8'hBB, 1'b0, 1'b0, "rs7");
        for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, "rs7_idle");
        drive(1'b1, 8'hCC, 1'b0, 1'b0, "rs7");
        drive(1'b1, 8'hDD, 1'b0, 1'b0, "rs7");
        chk("resync_7_kept", out_data, 32'hAABBCCDD);
        drive(1'b0, 8'h00, 1'b1, 1'b0, "rs7_pop");

        // 40 words interleaved with pops, crossing the pointer wrap.
        do_reset();
        prev = '0;
        for (int w = 0; w < 40; w++) begin
            if (w > 0) chk("wrap_order", out_data, prev);
            prev = 32'h5000_0000 + w * 32'h0001_0101;
            send_word(prev, 1'b1, 1'b0, "wrap");
        end
        chk("wrap_last", out_data, prev);
        drive(1'b0, 8'h00, 1'b1, 1'b0, "wrap_pop");
        chk("wrap_empty", {31'b0, out_valid}, 32'h0);

        // Random traffic against the model, alternating fill-heavy and drain-heavy phases.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            bit iv, rd, clr;
            int ph;
            ph  = (c / 400) % 2;
            iv  = $urandom_range(0, 99) < (ph != 0 ? 70 : 35);
            rd  = $urandom_range(0, 99) < (ph != 0 ? 15 : 60);
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) begin
                nidle = $urandom_range(5, 10);
                for (int k = 0; k < nidle; k++) drive(1'b0, 8'h00, rd, 1'b0, "rnd_idle");
            end
            drive(iv, 8'($urandom), rd, clr, "rnd");
        end

        // Async reset with 3 words queued and 2 bytes pending.
        do_reset();
        for (int i = 0; i < 3; i++) send_word(32'h6000_0000 + i, 1'b0, 1'b0, "pre_rst");
        drive(1'b1, 8'h77, 1'b0, 1'b0, "pre_rst");
        drive(1'b1, 8'h88, 1'b0, 1'b0, "pre_rst");
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_data", out_data, 32'h0);
        chk("async_rst_full", {31'b0, full}, 32'h0);
        chk("async_rst_ovf", {31'b0, overflow}, 32'h0);
        @(posedge CLK);
        #1;
        model_reset();
        reset = 1'b1;
        send_word(32'h0A0B0C0D, 1'b0, 1'b0, "post_rst");
        chk("post_rst_word", out_data, 32'h0A0B0C0D);
        drive(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_pop");
        chk("post_rst_single", {31'b0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
